// File: rtl/i2c_eeprom_slave.sv
// i2c_eeprom_slave: 24C02-style I2C target front-end driving a 32-page x 8-byte EEPROM array.
// Latency: 3 clk input sync; mem_write 1 clk after the 8th data SCL rise; SDA updates 1 clk after a detected SCL fall.
// Backpressure: none; the master owns SCL and this block never stretches the clock.
//
// Ports:
//   clk, rst            system clock (>= 16x SCL rate), async active-high reset
//   scl_i, sda_i        raw I2C pin levels (asynchronous to clk)
//   sda_oe              1 = pull SDA low (open-drain), 0 = release
//   mem_row, mem_col    array address = {page, byte-in-page} = address pointer
//   mem_write           one-clk write strobe, mem_wdata = byte to write
//   mem_rdata           combinational array read data for {mem_row, mem_col}
//   wp                  write protect (only when WRITE_PROTECT_EN is defined)
//
// Optional feature: define WRITE_PROTECT_EN to add the wp input. While wp is high,
// data bytes are still ACKed and the pointer still advances, but mem_write stays low.

module i2c_eeprom_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [4:0] mem_row,
  output logic [2:0] mem_col,
  output logic       mem_write,
  output logic [7:0] mem_wdata,
`ifdef WRITE_PROTECT_EN
  input  logic       wp,
`endif
  input  logic [7:0] mem_rdata
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_WORD_ADDR,
    ST_WORD_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK
  } state_t;

  state_t     state, state_nxt;

  // Input conditioning: two synchronizer flops plus one history flop per pin.
  // Reset to 1 so an idle bus produces no spurious edges when reset releases.
  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= scl_i;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda_i;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_rise  =  scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 &  scl_d;
  // SDA may only move while SCL is low; any SDA edge with SCL held high is a bus condition.
  assign start_det =  scl_s2 & scl_d &  sda_d & ~sda_s2;
  assign stop_det  =  scl_s2 & scl_d & ~sda_d &  sda_s2;

  logic wp_blk;

`ifdef WRITE_PROTECT_EN
  logic wp_s1, wp_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_s1 <= 1'b0;
      wp_s2 <= 1'b0;
    end else begin
      wp_s1 <= wp;
      wp_s2 <= wp_s1;
    end
  end

  assign wp_blk = wp_s2;
`else
  assign wp_blk = 1'b0;
`endif

  logic [3:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic [7:0] ptr, ptr_nxt;
  logic       rw, rw_nxt;           // R/W bit of the last matched device address
  logic       mst_ack, mst_ack_nxt; // master ACK (1) / NACK (0) after a read byte
  logic       col_inc, col_inc_nxt; // advance the in-page column the clk after a data byte
  logic       sda_oe_nxt;
  logic       mem_write_nxt;
  logic [7:0] mem_wdata_nxt;
  logic [7:0] rx_byte;

  assign mem_row = ptr[7:3];
  assign mem_col = ptr[2:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= 4'd0;
      shreg     <= 8'h00;
      ptr       <= 8'h00;
      rw        <= 1'b0;
      mst_ack   <= 1'b0;
      col_inc   <= 1'b0;
      sda_oe    <= 1'b0;
      mem_write <= 1'b0;
      mem_wdata <= 8'h00;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shreg     <= shreg_nxt;
      ptr       <= ptr_nxt;
      rw        <= rw_nxt;
      mst_ack   <= mst_ack_nxt;
      col_inc   <= col_inc_nxt;
      sda_oe    <= sda_oe_nxt;
      mem_write <= mem_write_nxt;
      mem_wdata <= mem_wdata_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    shreg_nxt     = shreg;
    ptr_nxt       = ptr;
    rw_nxt        = rw;
    mst_ack_nxt   = mst_ack;
    col_inc_nxt   = 1'b0;
    sda_oe_nxt    = sda_oe;
    mem_write_nxt = 1'b0;
    mem_wdata_nxt = mem_wdata;
    rx_byte       = {shreg[6:0], sda_s2};

    // Page wrap: only the column advances; the page bits stay put.
    if (col_inc) begin
      ptr_nxt = {ptr[7:3], ptr[2:0] + 3'd1};
    end

    if (start_det) begin
      // Also covers repeated START; a partially received data byte is dropped.
      state_nxt   = ST_DEV_ADDR;
      bit_cnt_nxt = 4'd0;
      sda_oe_nxt  = 1'b0;
    end else if (stop_det) begin
      state_nxt   = ST_IDLE;
      bit_cnt_nxt = 4'd0;
      sda_oe_nxt  = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
        end

        ST_DEV_ADDR, ST_WORD_ADDR, ST_WR_DATA: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            shreg_nxt   = rx_byte;
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              if (state == ST_WORD_ADDR) begin
                ptr_nxt = rx_byte;
              end
              if (state == ST_WR_DATA) begin
                mem_wdata_nxt = rx_byte;
                mem_write_nxt = ~wp_blk;
                col_inc_nxt   = 1'b1;
              end
            end
          end else if (scl_fall && bit_cnt == 4'd8) begin
            // Byte complete: drive ACK for the whole ninth clock.
            bit_cnt_nxt = 4'd0;
            sda_oe_nxt  = 1'b1;
            if (state == ST_DEV_ADDR) begin
              rw_nxt = shreg[0];
              if (shreg[7:1] == DEV_ADDR) begin
                state_nxt = ST_DEV_ACK;
              end else begin
                state_nxt  = ST_IDLE;
                sda_oe_nxt = 1'b0;
              end
            end else if (state == ST_WORD_ADDR) begin
              state_nxt = ST_WORD_ACK;
            end else begin
              state_nxt = ST_WR_ACK;
            end
          end
        end

        ST_DEV_ACK: begin
          if (scl_fall) begin
            bit_cnt_nxt = 4'd0;
            if (rw) begin
              // First read bit goes out on the same fall that ends the ACK.
              state_nxt  = ST_RD_DATA;
              shreg_nxt  = mem_rdata;
              sda_oe_nxt = ~mem_rdata[7];
            end else begin
              state_nxt  = ST_WORD_ADDR;
              sda_oe_nxt = 1'b0;
            end
          end
        end

        ST_WORD_ACK, ST_WR_ACK: begin
          if (scl_fall) begin
            state_nxt   = ST_WR_DATA;
            bit_cnt_nxt = 4'd0;
            sda_oe_nxt  = 1'b0;
          end
        end

        ST_RD_DATA: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              state_nxt   = ST_RD_ACK;
              bit_cnt_nxt = 4'd0;
              sda_oe_nxt  = 1'b0;
            end else begin
              shreg_nxt  = {shreg[6:0], 1'b0};
              sda_oe_nxt = ~shreg[6];
            end
          end
        end

        ST_RD_ACK: begin
          if (scl_rise) begin
            // Pointer advances after every byte read, ACKed or not, so a later
            // current-address read continues after the last byte delivered.
            mst_ack_nxt = ~sda_s2;
            ptr_nxt     = ptr + 8'd1;
          end else if (scl_fall) begin
            bit_cnt_nxt = 4'd0;
            if (mst_ack) begin
              state_nxt  = ST_RD_DATA;
              shreg_nxt  = mem_rdata;
              sda_oe_nxt = ~mem_rdata[7];
            end else begin
              state_nxt  = ST_IDLE;
              sda_oe_nxt = 1'b0;
            end
          end
        end

        default: begin
          state_nxt  = ST_IDLE;
          sda_oe_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// tb_i2c_eeprom_slave: directed bench for the I2C EEPROM target front-end.
// Latency: n/a (bit-banged master, quarter SCL period = Q clk).
// Backpressure: n/a.
`timescale 1ns/1ps

module tb_i2c_eeprom_slave;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m;
  logic       sda_m;
  logic       sda_line;
  logic       sda_oe;
  logic [4:0] mem_row;
  logic [2:0] mem_col;
  logic       mem_write;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
`ifdef WRITE_PROTECT_EN
  logic       wp;
`endif

  logic [7:0] mem [256] = '{default: 8'h00};
  logic [15:0] wlog [$];
  int          dbl_cnt = 0;
  int          oe_cnt  = 0;
  logic        wr_q    = 1'b0;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  assign sda_line  = sda_m & ~sda_oe;
  assign mem_rdata = mem[{mem_row, mem_col}];

  i2c_eeprom_slave #(.DEV_ADDR(7'h50)) dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_m),
    .sda_i     (sda_line),
    .sda_oe    (sda_oe),
    .mem_row   (mem_row),
    .mem_col   (mem_col),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
`ifdef WRITE_PROTECT_EN
    .wp        (wp),
`endif
    .mem_rdata (mem_rdata)
  );

  // Array model plus write log; sole writer of mem, wlog and the counters.
  always @(posedge clk) begin
    if (mem_write) begin
      wlog.push_back({mem_row, mem_col, mem_wdata});
      mem[{mem_row, mem_col}] = mem_wdata;
    end
    if (mem_write && wr_q) dbl_cnt++;
    wr_q = mem_write;
    if (sda_oe) oe_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL clock: SDA set while SCL low, line sampled mid SCL-high.
  task automatic bit_cycle(input logic b, output logic smp);
    sda_m = b;
    tick(Q);
    scl_m = 1'b1;
    tick(Q);
    smp = sda_line;
    tick(Q);
    scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic smp;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], smp);
    bit_cycle(1'b1, smp);
    ack = ~smp;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic smp;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_cycle(1'b1, smp);
      d = {d[6:0], smp};
    end
    bit_cycle(~ack, smp);
  endtask

  task automatic wr_txn(input logic [7:0] dev, input logic [7:0] waddr, input int n,
                        input logic [3:0][7:0] dat, output int acks);
    logic a;
    acks = 0;
    i2c_start;
    write_byte(dev, a);   if (a) acks++;
    write_byte(waddr, a); if (a) acks++;
    for (int i = 0; i < n; i++) begin
      write_byte(dat[i], a);
      if (a) acks++;
    end
    i2c_stop;
  endtask

  typedef struct {
    logic [7:0]      dev;
    logic [7:0]      waddr;
    int              n;
    logic [3:0][7:0] dat;      // dat[0] is sent first
    int              exp_acks;
    int              exp_wr;
    logic [7:0]      exp_ptr;
  } vec_t;

  vec_t vt [6];

  function automatic vec_t mkv(input logic [7:0] dev, input logic [7:0] waddr, input int n,
                               input logic [3:0][7:0] dat, input int exp_acks, input int exp_wr,
                               input logic [7:0] exp_ptr);
    vec_t v;
    v.dev = dev; v.waddr = waddr; v.n = n; v.dat = dat;
    v.exp_acks = exp_acks; v.exp_wr = exp_wr; v.exp_ptr = exp_ptr;
    return v;
  endfunction

  initial begin
    int         acks;
    int         wl0;
    int         oe0;
    logic       a;
    logic [7:0] d0, d1, d2;

    rst   = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
`ifdef WRITE_PROTECT_EN
    wp    = 1'b0;
`endif

    // Byte write, page wrap (1E,1F,18,19), address mismatch, two-byte write,
    // then two writes that set up the read test (FE=77, FF=88, 00=99, 01=3C).
    vt[0] = mkv(8'hA0, 8'h2B, 1, {8'h00, 8'h00, 8'h00, 8'h5C}, 3, 1, 8'h2C);
    vt[1] = mkv(8'hA0, 8'h1E, 4, {8'h44, 8'h33, 8'h22, 8'h11}, 6, 4, 8'h1A);
    vt[2] = mkv(8'hA2, 8'h10, 2, {8'h00, 8'h00, 8'hBB, 8'hAA}, 0, 0, 8'h1A);
    vt[3] = mkv(8'hA0, 8'hF8, 2, {8'h00, 8'h00, 8'hC2, 8'hC1}, 4, 2, 8'hFA);
    vt[4] = mkv(8'hA0, 8'hFE, 2, {8'h00, 8'h00, 8'h88, 8'h77}, 4, 2, 8'hF8);
    vt[5] = mkv(8'hA0, 8'h00, 2, {8'h00, 8'h00, 8'h3C, 8'h99}, 4, 2, 8'h02);

    tick(3);
    check("rst sda_oe",    sda_oe,              0);
    check("rst mem_write", mem_write,           0);
    check("rst mem_wdata", mem_wdata,           0);
    check("rst ptr",       {mem_row, mem_col},  0);
    rst = 1'b0;
    tick(Q);

    for (int v = 0; v < 6; v++) begin
      wl0 = wlog.size();
      oe0 = oe_cnt;
      wr_txn(vt[v].dev, vt[v].waddr, vt[v].n, vt[v].dat, acks);
      check($sformatf("v%0d acks", v),   acks,                vt[v].exp_acks);
      check($sformatf("v%0d writes", v), wlog.size() - wl0,   vt[v].exp_wr);
      check($sformatf("v%0d ptr", v),    {mem_row, mem_col},  vt[v].exp_ptr);
      check($sformatf("v%0d sda_oe used", v), (oe_cnt != oe0), (vt[v].exp_acks != 0));
      for (int i = 0; i < vt[v].exp_wr && wl0 + i < wlog.size(); i++) begin
        logic [2:0] c;
        c = vt[v].waddr[2:0] + 3'(i);
        check($sformatf("v%0d wr%0d row/col/data", v, i), wlog[wl0 + i],
              {vt[v].waddr[7:3], c, vt[v].dat[i]});
      end
    end

    // Random read at FE via repeated START, sequential across the FF->00 wrap.
    wl0  = wlog.size();
    acks = 0;
    i2c_start;
    write_byte(8'hA0, a); if (a) acks++;
    write_byte(8'hFE, a); if (a) acks++;
    i2c_start;
    write_byte(8'hA1, a); if (a) acks++;
    read_byte(1'b1, d0);
    read_byte(1'b1, d1);
    read_byte(1'b0, d2);
    i2c_stop;
    check("rd acks",   acks, 3);
    check("rd byte0",  d0, 8'h77);
    check("rd byte1",  d1, 8'h88);
    check("rd byte2",  d2, 8'h99);
    check("rd ptr",    {mem_row, mem_col}, 8'h01);
    check("rd sda released", sda_oe, 0);
    check("rd no writes", wlog.size() - wl0, 0);

    // Current-address read continues from the pointer left by the last read.
    i2c_start;
    write_byte(8'hA1, a);
    read_byte(1'b0, d0);
    i2c_stop;
    check("cur ack",  a,  1);
    check("cur byte", d0, 8'h3C);
    check("cur ptr",  {mem_row, mem_col}, 8'h02);

    // STOP after 4 bits of a data byte: no write, pointer stays at word address.
    wl0 = wlog.size();
    i2c_start;
    write_byte(8'hA0, a);
    write_byte(8'h40, a);
    for (int i = 0; i < 4; i++) bit_cycle(1'b0, a);
    i2c_stop;
    check("abort no write", wlog.size() - wl0, 0);
    check("abort ptr",      {mem_row, mem_col}, 8'h40);

    // Read of 0x40 (=00) drives SDA low on bit 7; reset mid-bit releases it asynchronously.
    i2c_start;
    write_byte(8'hA1, a);
    check("rd40 ack", a, 1);
    sda_m = 1'b1;
    tick(Q);
    scl_m = 1'b1;
    tick(Q);
    check("rd40 bit7 driven", sda_oe, 1);
    #2 rst = 1'b1;
    #1 check("async release", sda_oe, 0);
    tick(2);
    rst = 1'b0;
    check("post-rst ptr", {mem_row, mem_col}, 8'h00);
    scl_m = 1'b0;
    tick(Q);
    i2c_stop;
    check("abort+rst no write", wlog.size() - wl0, 0);

    wl0 = wlog.size();
    wr_txn(8'hA0, 8'h60, 1, {8'h00, 8'h00, 8'h00, 8'hA5}, acks);
    check("recover acks",  acks, 3);
    check("recover writes", wlog.size() - wl0, 1);
    if (wlog.size() > wl0) check("recover wr", wlog[wl0], {8'h60, 8'hA5});
    check("recover ptr",   {mem_row, mem_col}, 8'h61);

`ifdef WRITE_PROTECT_EN
    wp = 1'b1;
    tick(4);
    wl0 = wlog.size();
    wr_txn(8'hA0, 8'h10, 1, {8'h00, 8'h00, 8'h00, 8'hAB}, acks);
    check("wp acks",   acks, 3);
    check("wp writes", wlog.size() - wl0, 0);
    check("wp ptr",    {mem_row, mem_col}, 8'h11);
    wp = 1'b0;
`endif

    check("single-clk strobe", dbl_cnt, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/i2c_eeprom_slave.md
Name: i2c_eeprom_slave

Overview:
- I2C responder (target) front-end for the 32-page x 8-byte EEPROM storage array: decodes START/STOP, device address, word address and data from SCL/SDA, and drives the array's row/col/write/data port.
- Implements 24C02-style protocol: byte/page write with in-page column wrap, random read, current-address read and sequential read.
- Sits between the board-level open-drain I2C pins and the EEPROM array.

Parameters:
- DEV_ADDR, 7'h50, 7-bit I2C device address this block responds to.

Ports:
- clk  input  1  system clock; must be at least 16x the SCL bit rate.
- rst  input  1  asynchronous, active-high reset.
- scl_i  input  1  SCL pin level, asynchronous to clk.
- sda_i  input  1  SDA pin level, asynchronous to clk.
- sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
- mem_row  output  5  array page select = word address [7:3].
- mem_col  output  3  byte within page = word address [2:0].
- mem_write  output  1  one-clk write strobe to the array.
- mem_wdata  output  8  write data to the array.
- mem_rdata  input  8  array read data for {mem_row, mem_col}; combinational from the address.

Behaviour:
- Input conditioning: scl_i and sda_i each pass through a 2-flop synchronizer plus one history flop. Edge and condition detection uses the synchronized values only.
- START = SDA falls while SCL high. STOP = SDA rises while SCL high.
- Data bits are sampled on the SCL rising edge. sda_oe changes only in the clk cycle after an SCL falling edge is detected.
- Address pointer ptr[7:0] drives {mem_row, mem_col}.
- Reset values (asynchronous): sda_oe=0, mem_write=0, mem_wdata=0, ptr=0, state=IDLE, bit counter=0.
- State machine states: IDLE, DEV_ADDR, DEV_ACK, WORD_ADDR, WORD_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
- From any state: START -> DEV_ADDR with bit counter cleared (covers repeated START). STOP -> IDLE with sda_oe released. A START or STOP inside WR_DATA before bit 8 discards the partial byte.
- DEV_ADDR: shift in 8 bits MSB first.
  - Bits[7:1] != DEV_ADDR -> IDLE, no ACK, ignore the bus until the next START.
  - Match -> DEV_ACK; sda_oe=1 from the following SCL fall until the next SCL fall.
  - After DEV_ACK: R/W=0 -> WORD_ADDR. R/W=1 -> RD_DATA (current-address read from ptr).
- WORD_ADDR: shift in 8 bits, load ptr, then WORD_ACK (ACK driven), then WR_DATA.
- WR_DATA: shift in 8 bits.
  - The clk after the 8th SCL rise: mem_wdata=byte, mem_write=1 for exactly one clk, row/col = ptr.
  - The next clk: ptr[2:0] increments mod 8 and ptr[7:3] is unchanged (page wrap: the 9th byte in one transaction overwrites col 0 of the same page).
  - Then WR_ACK drives ACK and returns to WR_DATA.
- RD_DATA:
  - On entry, at the SCL fall that ends the ACK, load the shift register from mem_rdata.
  - Drive each bit via sda_oe = ~bit, MSB first, changing on SCL falls.
  - After the 8th bit, release SDA for RD_ACK.
- RD_ACK: sample SDA at the SCL rise.
  - Low (ACK): ptr increments mod 256 (full-array wrap, 8'hFF -> 8'h00), then RD_DATA.
  - High (NACK): IDLE; ptr holds its last incremented value.
- A random read is a write of the word address followed by a repeated START and R/W=1. ptr is already loaded, so the read starts at that address.
- mem_write is never asserted outside WR_DATA byte completion. No write occurs for a byte interrupted by START or STOP.
- Reset mid-transfer releases SDA immediately and asynchronously. The block then ignores the bus until a fresh START.

Optional Feature:
- Macro WRITE_PROTECT_EN.
- Defined: adds input port wp (1 bit, synchronized with 2 flops). While wp=1, data bytes in WR_DATA are still ACKed and ptr still advances, but mem_write stays 0. Word-address loads and reads are unaffected.
- Undefined: no wp port; writes always occur.

Test Plan:
- Byte write: START, 0xA0, 0x2B, 0x5C, STOP -> ACK on all 3 bytes; one mem_write pulse with row=5, col=3, wdata=0x5C; ptr=0x2C.
- Page wrap: write at 0x1E with 4 bytes 11,22,33,44 -> writes land at cols 6,7,0,1 of row 3; ptr ends at 0x1A.
- Random/sequential read: preload 0xFE=0x77, 0xFF=0x88, 0x00=0x99. Send START, A0, FE, rSTART, A1; read 3 bytes with ACK, ACK, NACK -> SDA shows 0x77, 0x88, 0x99; ptr=0x01; state IDLE.
- Address mismatch: START, 0xA2, ... -> sda_oe stays 0 for the entire transaction; no mem_write.
- Abort: STOP after 4 bits of a data byte, then reset asserted mid-READ bit -> no write; sda_oe drops asynchronously; next valid transaction succeeds.
- WRITE_PROTECT_EN with wp=1: byte write to 0x10 -> all bytes ACKed; mem_write never asserted; ptr=0x11.
